// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, scheduler FSM states and the legal-opcode helper
package alu_pkg;
  typedef logic [2:0] alu_ctrl_t;
  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
  function automatic logic ctrl_legal(input alu_ctrl_t c);
    return c inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational AND/OR/ADD/SUB/SLT unit; unused codes yield zero
module alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctrl_t        alucontrol,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] diff;
  assign diff = a - b;
  assign result = alucontrol == ALU_AND ? a & b :
                  alucontrol == ALU_OR  ? a | b :
                  alucontrol == ALU_ADD ? a + b :
                  alucontrol == ALU_SUB ? diff :
                  alucontrol == ALU_SLT ? WIDTH'(diff[WIDTH-1]) : '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after last_grant, with wrap
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);
  localparam int IDW = $clog2(NREQ);
  int   idx;
  logic found;
  // scan NREQ slots from last_grant+1; the first valid one wins
  always_comb begin
    idx = 0;
    found = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
    gnt = found ? NREQ'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one ALU among NREQ requesters in round-robin order.
// Optional macro ALU_RR_ILLEGAL_CHK_EN adds rsp_err and zeroes results of illegal codes.
module alu_rr_sched import alu_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*3-1:0]       req_ctrl,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  output logic                    busy
`ifdef ALU_RR_ILLEGAL_CHK_EN
  ,
  output logic                    rsp_err
`endif
);
  localparam int IDW = $clog2(NREQ);
  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   last_q, last_d, gnt_idx, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, alu_res, res_q, res_d;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic             rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [NREQ-1:0]  gnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid), .last_grant(last_q), .gnt(gnt), .gnt_idx(gnt_idx)
  );
  alu #(.WIDTH(WIDTH)) u_alu (
    .a(a_q), .b(b_q), .alucontrol(ctrl_q), .result(alu_res)
  );
  // ready only while idle; gated by reset so it reads zero during reset as well
  assign req_ready = (state_q == IDLE && !reset) ? gnt : '0;
  assign busy = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = res_q;
`ifdef ALU_RR_ILLEGAL_CHK_EN
  assign rsp_err = err_q;
`endif
  // next-state: accept in IDLE, capture ALU result in EXEC, hold in RESP until taken
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    a_d = a_q;
    b_d = b_q;
    ctrl_d = ctrl_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    res_d = res_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = EXEC;
        last_d = gnt_idx;
        a_d = req_a[gnt_idx*WIDTH +: WIDTH];
        b_d = req_b[gnt_idx*WIDTH +: WIDTH];
        ctrl_d = req_ctrl[gnt_idx*3 +: 3];
      end
      EXEC: begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d = last_q;
`ifdef ALU_RR_ILLEGAL_CHK_EN
        res_d = ctrl_legal(ctrl_q) ? alu_res : '0;
        err_d = !ctrl_legal(ctrl_q);
`else
        res_d = alu_res;
        err_d = 1'b0;
`endif
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      a_q <= '0;
      b_q <= '0;
      ctrl_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      a_q <= a_d;
      b_q <= b_d;
      ctrl_q <= ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: directed and random checks of alu_rr_sched against a behavioural model
module tb_alu_rr_sched;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, rsp_valid, rsp_ready, busy;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_ctrl;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_result;
`ifdef ALU_RR_ILLEGAL_CHK_EN
  logic rsp_err;
`endif
  logic [W-1:0] ta [N];
  logic [W-1:0] tbv [N];
  logic [2:0] tc [N];
  int n_chk = 0;
  int n_fail = 0;
  int last_g;

  alu_rr_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
`ifdef ALU_RR_ILLEGAL_CHK_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_ctrl = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tbv[i];
      req_ctrl[i*3 +: 3] = tc[i];
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    logic [W-1:0] d = a - b;
    case (c)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b110: return d;
      3'b111: return d >> (W - 1);
      default: return '0;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic op(input int stall);
    int g;
    logic [W-1:0] er;
    #1;
    g = pick(req_valid, last_g);
    if (g < 0) begin
      chk("no_request", 32'(req_valid), 32'hF);
      return;
    end
    er = ref_alu(ta[g], tbv[g], tc[g]);
    chk("grant", 32'(req_ready), 32'(1) << g);
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_result", rsp_result, er);
`ifdef ALU_RR_ILLEGAL_CHK_EN
    chk("rsp_err", 32'(rsp_err), 32'(tc[g] inside {3'd3, 3'd4, 3'd5}));
`endif
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_id", 32'(rsp_id), 32'(g));
      chk("stall_result", rsp_result, er);
      chk("stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 0);
    chk("done_busy", 32'(busy), 0);
    last_g = g;
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0;
      tbv[i] = '0;
      tc[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = 4'b0010;
    ta[1] = 100;
    tbv[1] = 23;
    tc[1] = 3'b010;
    reset = 1'b0;
    last_g = N - 1;
    op(0);
    req_valid = 4'b0100;
    ta[2] = 9;
    tbv[2] = 4;
    tc[2] = 3'b010;
    #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      ta[i] = 50;
      tbv[i] = 75;
      tc[i] = 3'b110;
    end
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_result", rsp_result, 0);
    chk("midrst_id", 32'(rsp_id), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_g = N - 1;
    for (int i = 0; i < 5; i++) begin
      op(0);
      chk("sub_order", 32'(last_g), 32'(i % N));
    end
    req_valid = 4'b0100;
    ta[2] = 5; tbv[2] = 10; tc[2] = 3'b111;
    op(0);
    ta[2] = 20; tbv[2] = 10;
    op(0);
    ta[2] = 32'hA5A5A5A5; tbv[2] = 32'h5A5A5A5A; tc[2] = 3'b000;
    op(0);
    req_valid = 4'b1000;
    ta[3] = 7; tbv[3] = 3; tc[3] = 3'b010;
    op(5);
    req_valid = 4'b0001;
    ta[0] = 32'hFFFFFFFF; tbv[0] = 0; tc[0] = 3'b011;
    op(0);
    tc[0] = 3'b001;
    op(0);
    req_valid = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ready", 32'(req_ready), 0);
      chk("idle_stay", 32'(busy), 0);
    end
    for (int t = 0; t < 40; t++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        ta[i] = $urandom;
        tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
        tc[i] = 3'($urandom_range(0, 7));
      end
      op(int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one pipeline `alu` instance among NREQ requesters, e.g. an EX-stage ALU plus multi-cycle helper units.
- Each requester presents operands a/b and a 3-bit alucontrol with a valid/ready handshake.
- The block grants one requester, latches its operands, executes on the ALU and returns a tagged result over a valid/ready response channel.
- Sits between requesters and the single ALU; the ALU itself is unmodified.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width; must match alu
- IDW, $clog2(NREQ), requester-id width (derived, localparam)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept, one-hot or zero
- req_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- req_ctrl  input  NREQ*3  alucontrol per requester, [i*3 +: 3]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  IDW  index of the requester that owns the response
- rsp_result  output  WIDTH  ALU result
- busy  output  1  high in EXEC or RESP

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, req_ready=0, last_grant=NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_valid is set, grant g = first valid index searching (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally in that cycle only; the handshake completes that cycle.
  - On the clock edge: latch a/b/ctrl/g, set last_grant=g, go to EXEC.
  - No valid requests: stay in IDLE with req_ready=0.
- req_ready is 0 in EXEC and RESP. A requester must hold valid/operands stable until ready. Dropping valid before grant is allowed.
- EXEC:
  - ALU driven only from latched operands.
  - rsp_result<=alu.result and rsp_id<=latched g; go to RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_id held stable.
  - On rsp_valid&&rsp_ready: go to IDLE, rsp_valid<=0.
  - rsp_ready held low stalls indefinitely.
- Latency: accept at edge T, rsp_valid high from T+2. Peak throughput is one op per 3 cycles. No new accept in the cycle the response completes; arbitration resumes the next cycle.
- ALU codes (bit-exact with alu):
  - 000 AND, 001 OR, 010 ADD (mod 2^WIDTH), 110 SUB (a-b mod 2^WIDTH).
  - 111 SLT: result = {WIDTH-1 zeros, MSB of (a-b)}; overflow ignored.
  - 011/100/101: result as produced by alu (all zeros).
- Wrap-around: last_grant=NREQ-1 searches from 0.
- Simultaneous valid requests are served strictly in rotating order. A single persistent requester is re-granted every op.
- Reset mid-operation (EXEC/RESP): in-flight op discarded, all outputs return to reset values immediately. The requester has already seen ready and gets no response.

Optional Feature:
- ALU_RR_ILLEGAL_CHK_EN
- Defined:
  - Adds output rsp_err (1 bit, reset 0), valid with rsp_valid.
  - Codes 011/100/101 set rsp_err=1 and force rsp_result=0, independent of the alu output.
  - Legal codes give rsp_err=0.
- Undefined: no rsp_err port; the result is the raw alu output.

Decomposition:
- Package alu_pkg:
  - ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111
  - typedef alu_ctrl_t (logic [2:0])
  - enum sched_state_t {IDLE, EXEC, RESP}
- Sub-module rr_arbiter: combinational round-robin grant. Inputs req[NREQ] and last_grant; outputs one-hot gnt and gnt_idx.
- Existing alu instantiated once, unchanged.

Test Plan:
- Reset asserted mid-RESP with rsp_ready=0 -> rsp_valid/req_ready/busy drop immediately. After release, first grant goes to req0 when all valid.
- Single op: req1 valid, a=100, b=23, ctrl=010 -> req_ready[1] pulse one cycle. Two cycles later rsp_valid=1, rsp_id=1, rsp_result=123.
- All 4 valid continuously with ctrl=110 (a=50, b=75) -> grants in order 0,1,2,3,0. Every result is 0xFFFFFFE7, with matching rsp_id sequence.
- SLT: a=5, b=10 -> result 1; a=20, b=10 -> result 0. AND 0xA5A5A5A5 & 0x5A5A5A5A -> 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> result and id stable, req_ready=0 throughout. Release -> IDLE next cycle, then the next grant.
- ctrl=011, a=0xFFFFFFFF, b=0 -> result 0. With ALU_RR_ILLEGAL_CHK_EN, rsp_err=1; ctrl=001 afterwards gives rsp_err=0.
